// File: rtl/block_fetch_unit.sv
// Block fetch unit: walks an output grid, reads source pixels and
// presents 2x2 pixel blocks to a downstream resizing core.
module block_fetch_unit #(
    parameter int SRC_W  = 320,
    parameter int SRC_H  = 240,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] src_base,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              blk_valid,
    input  logic              blk_ready,
    output logic              blk_last,
    output logic [7:0]        p_out_00,
    output logic [7:0]        p_out_01,
    output logic [7:0]        p_out_10,
    output logic [7:0]        p_out_11,
    output logic [1:0]        alg_sel
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_READ = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_OUT  = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    localparam int MAXD = (SRC_W > SRC_H) ? SRC_W : SRC_H;
    localparam int CW   = $clog2(2 * MAXD) + 1;

    localparam logic [CW-1:0] LP_XH = CW'(SRC_W / 2 - 1);
    localparam logic [CW-1:0] LP_YH = CW'(SRC_H / 2 - 1);
    localparam logic [CW-1:0] LP_XD = CW'(2 * SRC_W - 1);
    localparam logic [CW-1:0] LP_YD = CW'(2 * SRC_H - 1);

    localparam logic [ADDR_W-1:0] LP_W  = ADDR_W'(SRC_W);
    localparam logic [ADDR_W-1:0] LP_W1 = ADDR_W'(SRC_W + 1);
    localparam logic [ADDR_W-1:0] LP_W2 = ADDR_W'(2 * SRC_W);

    logic [2:0]        r_state;
    logic [1:0]        r_mode;
    logic [ADDR_W-1:0] r_base;
    logic [CW-1:0]     r_x;
    logic [CW-1:0]     r_y;
    logic [1:0]        r_idx;
    logic              r_cap_v;
    logic [1:0]        r_cap_idx;
    logic [7:0]        r_p00;
    logic [7:0]        r_p01;
    logic [7:0]        r_p10;
    logic [7:0]        r_p11;
    logic              r_done;

    logic              w_up;
    logic [CW-1:0]     w_xmax;
    logic [CW-1:0]     w_ymax;
    logic              w_x_end;
    logic              w_last;
    logic [1:0]        w_nlast;
    logic [ADDR_W-1:0] w_a00;
    logic [ADDR_W-1:0] w_a10;
    logic [ADDR_W-1:0] w_off;
    logic [ADDR_W-1:0] w_addr;

    assign w_up    = (r_mode == 2'b10);
    assign w_xmax  = w_up ? LP_XD : LP_XH;
    assign w_ymax  = w_up ? LP_YD : LP_YH;
    assign w_x_end = (r_x == w_xmax);
    assign w_last  = w_x_end && (r_y == w_ymax);
    assign w_nlast = (r_mode == 2'b01) ? 2'd3 : 2'd0;

    assign w_a00 = r_base + ADDR_W'(r_y) * LP_W2 + (ADDR_W'(r_x) << 1);
    assign w_a10 = r_base + ADDR_W'(r_y >> 1) * LP_W + ADDR_W'(r_x >> 1);

    // 2x2 neighbourhood offsets in read order; r_idx stays 0 outside mode 01
    always_comb begin
        w_off = '0;
        unique case (r_idx)
            2'd1:    w_off = ADDR_W'(1);
            2'd2:    w_off = LP_W;
            2'd3:    w_off = LP_W1;
            default: w_off = '0;
        endcase
    end

    assign w_addr = w_up ? w_a10 : (w_a00 + w_off);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_mode    <= 2'b00;
            r_base    <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_idx     <= 2'd0;
            r_cap_v   <= 1'b0;
            r_cap_idx <= 2'd0;
            r_p00     <= 8'd0;
            r_p01     <= 8'd0;
            r_p10     <= 8'd0;
            r_p11     <= 8'd0;
            r_done    <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_cap_v   <= (r_state == S_READ);
            r_cap_idx <= r_idx;
            if (r_cap_v) begin
                unique case (r_cap_idx)
                    2'd0: r_p00 <= rd_data;
                    2'd1: r_p01 <= rd_data;
                    2'd2: r_p10 <= rd_data;
                    2'd3: r_p11 <= rd_data;
                endcase
            end
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode  <= mode;
                        r_base  <= src_base;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_idx   <= 2'd0;
                        r_p00   <= 8'd0;
                        r_p01   <= 8'd0;
                        r_p10   <= 8'd0;
                        r_p11   <= 8'd0;
                        r_state <= (mode == 2'b11) ? S_ERR : S_READ;
                    end
                end
                S_READ: begin
                    if (r_idx == w_nlast) begin
                        r_idx   <= 2'd0;
                        r_state <= S_WAIT;
                    end else begin
                        r_idx <= r_idx + 2'd1;
                    end
                end
                S_WAIT: r_state <= S_OUT;
                S_OUT: begin
                    if (blk_ready) begin
                        if (w_last) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_READ;
                            if (w_x_end) begin
                                r_x <= '0;
                                r_y <= r_y + CW'(1);
                            end else begin
                                r_x <= r_x + CW'(1);
                            end
                        end
                    end
                end
                S_ERR:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign cfg_err   = (r_state == S_ERR);
    assign done      = r_done || cfg_err;
    assign rd_en     = (r_state == S_READ);
    assign rd_addr   = rd_en ? w_addr : '0;
    assign blk_valid = (r_state == S_OUT);
    assign blk_last  = blk_valid && w_last;
    assign p_out_00  = r_p00;
    assign p_out_01  = r_p01;
    assign p_out_10  = r_p10;
    assign p_out_11  = r_p11;
    assign alg_sel   = {1'b0, (r_mode == 2'b01)};

endmodule
